// File: rtl/cpuc_out_collector_if.sv
// cpuc_out_collector_if: read port of the CPUC output collector.
//   rd_data  : head entry {stamp, mask, v1, v2}, zero while empty
//   rd_valid : FIFO non-empty
//   rd_ready : consumer accepts the head entry
//   count    : current FIFO occupancy
//   overflow : sticky, a push was dropped because the FIFO was full
// master = collector side, slave = consumer side.
interface cpuc_out_collector_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TSW   = 16
);
    localparam int unsigned EW = TSW + 2 + 2 * W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output rd_data,
        output rd_valid,
        output count,
        output overflow,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        input  count,
        input  overflow,
        output rd_ready
    );
endinterface

// File: rtl/cpuc_out_collector.sv
// cpuc_out_collector: watches CPUC out1/out2 and logs every value change as a
// timestamped entry in a small registered FIFO drained over a valid/ready port.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   en   : capture enable, gates sampling and the cycle counter
//   out1 : observed CPUC output 1
//   out2 : observed CPUC output 2
//   rd   : read port (rd_data, rd_valid, rd_ready, count, overflow)
module cpuc_out_collector #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TSW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [W-1:0]          out1,
    input  logic [W-1:0]          out2,
    cpuc_out_collector_if.master  rd
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = TSW + 2 + 2 * W;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [TSW-1:0] cyc_q, cyc_d;
    logic [W-1:0]   prev1_q, prev1_d;
    logic [W-1:0]   prev2_q, prev2_d;
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic [EW-1:0]  mem [DEPTH];

    logic [1:0]     mask;
    logic [EW-1:0]  entry;
    logic           push_req, push, pop, full, not_empty;

    always_comb begin
        mask       = {out1 != prev1_q, out2 != prev2_q};
        entry      = {cyc_q, mask, out1, out2};
        not_empty  = count_q != '0;
        full       = count_q == FULL_COUNT;
        // en gates the compare so unknown inputs while disabled never push
        push_req   = en && (mask != 2'b00);
        pop        = not_empty && rd.rd_ready;
        // a full FIFO still accepts a push when a pop frees a slot this cycle
        push       = push_req && (!full || pop);

        cyc_d      = en ? cyc_q + TSW'(1) : cyc_q;
        prev1_d    = en ? out1 : prev1_q;
        prev2_d    = en ? out2 : prev2_q;
        wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | (push_req && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= '0;
            prev1_q    <= '0;
            prev2_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cyc_q      <= cyc_d;
            prev1_q    <= prev1_d;
            prev2_q    <= prev2_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr_q] <= entry;
        end
    end

    assign rd.rd_valid = not_empty;
    assign rd.rd_data  = not_empty ? mem[rptr_q] : '0;
    assign rd.count    = count_q;
    assign rd.overflow = overflow_q;
endmodule

// File: tb/tb_cpuc_out_collector.sv
module tb_cpuc_out_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] out1;
    logic [15:0] out2;
    int          checks = 0;
    int          errors = 0;

    cpuc_out_collector_if #(.W(16), .DEPTH(8), .TSW(16)) rdif ();

    cpuc_out_collector #(.W(16), .DEPTH(8), .TSW(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .out1 (out1),
        .out2 (out2),
        .rd   (rdif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ent(input int stamp, input logic [1:0] m,
                                        input logic [15:0] a, input logic [15:0] b);
        return {14'b0, 16'(stamp), m, a, b};
    endfunction

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [63:0] rdd();
        return {14'b0, rdif.rd_data};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; out1 = '0; out2 = '0; rdif.rd_ready = 1'b0;
        #1;
        do_reset();
        chk("reset_valid", 64'(rdif.rd_valid), 64'd0);
        chk("reset_count", 64'(rdif.count), 64'd0);
        chk("reset_data", rdd(), 64'd0);

        // Quiet outputs: nothing logged.
        for (int i = 0; i < 5; i++) step();
        chk("quiet_valid", 64'(rdif.rd_valid), 64'd0);
        chk("quiet_count", 64'(rdif.count), 64'd0);
        chk("quiet_ovf", 64'(rdif.overflow), 64'd0);

        // Single change on out1 sampled at cyc=3.
        do_reset();
        step(); step(); step();
        chk("pre_change_valid", 64'(rdif.rd_valid), 64'd0);
        out1 = 16'h0005;
        step();
        chk("one_valid", 64'(rdif.rd_valid), 64'd1);
        chk("one_count", 64'(rdif.count), 64'd1);
        chk("one_data", rdd(), ent(3, 2'b10, 16'h0005, 16'h0000));
        rdif.rd_ready = 1'b1;
        step();
        rdif.rd_ready = 1'b0;
        chk("one_pop_count", 64'(rdif.count), 64'd0);
        chk("one_pop_valid", 64'(rdif.rd_valid), 64'd0);

        // Simultaneous change on both outputs at cyc=7: one entry.
        step(); step();
        out1 = 16'h0011; out2 = 16'h0022;
        step();
        chk("both_count", 64'(rdif.count), 64'd1);
        chk("both_data", rdd(), ent(7, 2'b11, 16'h0011, 16'h0022));
        rdif.rd_ready = 1'b1;
        step();
        rdif.rd_ready = 1'b0;
        chk("both_pop_count", 64'(rdif.count), 64'd0);

        // Overflow: 10 changes into an 8-deep FIFO with no reads.
        out1 = '0; out2 = '0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            out2 = 16'(i + 1);
            step();
            if (i == 7) begin
                chk("full_count", 64'(rdif.count), 64'd8);
                chk("full_no_ovf", 64'(rdif.overflow), 64'd0);
            end
        end
        chk("ovf_count", 64'(rdif.count), 64'd8);
        chk("ovf_flag", 64'(rdif.overflow), 64'd1);
        step();
        chk("ovf_head_stable", rdd(), ent(0, 2'b01, 16'h0000, 16'h0001));
        rdif.rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d", k), rdd(), ent(k, 2'b01, 16'h0000, 16'(k + 1)));
            step();
        end
        rdif.rd_ready = 1'b0;
        chk("drain_valid", 64'(rdif.rd_valid), 64'd0);
        chk("drain_ovf_sticky", 64'(rdif.overflow), 64'd1);

        // Full FIFO, push and pop in the same cycle.
        out2 = '0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            out2 = 16'(i + 1);
            step();
        end
        chk("pp_full_count", 64'(rdif.count), 64'd8);
        out2 = 16'd100;
        rdif.rd_ready = 1'b1;
        step();
        rdif.rd_ready = 1'b0;
        chk("pp_count", 64'(rdif.count), 64'd8);
        chk("pp_no_ovf", 64'(rdif.overflow), 64'd0);
        rdif.rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pp_drain%0d", k), rdd(),
                ent(k + 1, 2'b01, 16'h0000, (k < 7) ? 16'(k + 2) : 16'd100));
            step();
        end
        rdif.rd_ready = 1'b0;
        chk("pp_empty", 64'(rdif.rd_valid), 64'd0);

        // en=0 holds counter and prev regs and ignores X; rst discards entries.
        out1 = '0; out2 = '0;
        do_reset();
        out1 = 16'h0001;
        step();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            out1 = 16'(16'h0020 + i);
            out2 = 'x;
            step();
        end
        chk("en0_count", 64'(rdif.count), 64'd1);
        out2 = '0;
        en = 1'b1;
        step();
        chk("en1_count", 64'(rdif.count), 64'd2);
        chk("en1_head", rdd(), ent(0, 2'b10, 16'h0001, 16'h0000));
        rdif.rd_ready = 1'b1;
        step();
        rdif.rd_ready = 1'b0;
        chk("en_hold_stamp", rdd(), ent(1, 2'b10, 16'h0023, 16'h0000));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_count", 64'(rdif.count), 64'd0);
        chk("rst_valid", 64'(rdif.rd_valid), 64'd0);
        step();
        chk("rst_restart", rdd(), ent(0, 2'b10, 16'h0023, 16'h0000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpuc_out_collector.md
Name: cpuc_out_collector

Overview:
- Observer for the other end of the CPUC I/O interface: samples CPUC `out1`/`out2` every clock and records each value change as a timestamped entry.
- Entries go into a small FIFO that a bench or host drains through a valid/ready read port.
- Used by self-checking benches and the board-level debug path in place of waveform inspection.

Parameters:
- W, 16, data width of out1/out2; must match the CPUC W.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TSW, 16, timestamp (cycle counter) width.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable; gates both sampling and the cycle counter.
- out1  in  W  CPUC output 1 (observed).
- out2  in  W  CPUC output 2 (observed).
- rd_data  out  TSW+2+2W  entry = {stamp[TSW-1:0], mask[1:0], v1[W-1:0], v2[W-1:0]}; mask[1] = out1 changed, mask[0] = out2 changed.
- rd_valid  out  1  FIFO non-empty; rd_data is valid.
- rd_ready  in  1  consumer accepts the head entry when rd_valid & rd_ready.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a push was dropped because the FIFO was full.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - cyc=0, prev1=0, prev2=0, FIFO empty.
  - rd_valid=0, count=0, overflow=0, rd_data=0.
  - Reset mid-operation discards all stored entries; rst has priority over every other event.
- Cycle counter: at each edge with en=1, cyc <= cyc+1. Wraps from 2^TSW-1 to 0 with no flag. Holds while en=0.
- Change detect, at each edge with en=1:
  - mask = {out1!=prev1, out2!=prev2}.
  - prev1 <= out1, prev2 <= out2.
  - If mask!=0, push one entry {cyc (pre-increment value), mask, out1, out2}.
  - A simultaneous change on both outputs gives a single entry with mask=2'b11, never two entries.
  - With en=0: no compare, no push, prev registers hold.
- Baseline is 0: a nonzero output after reset is logged as a change.
- FIFO:
  - Registered, no fall-through. A push into an empty FIFO makes rd_valid=1 on the following cycle, i.e. 1-cycle latency from the sampling edge to rd_valid.
  - rd_data always shows the head entry; it is stable while rd_valid=1 and rd_ready=0.
  - Pop occurs when rd_valid & rd_ready; the next entry (if any) is presented on the next cycle.
  - Pointers wrap modulo DEPTH.
- Full:
  - A push with count==DEPTH and no pop in the same cycle is dropped; the FIFO contents are unchanged and overflow <= 1, holding until rst.
  - Push and pop in the same cycle while full: both are performed, count stays DEPTH, no overflow.
- Empty: rd_ready with rd_valid=0 has no effect. Push and pop in the same cycle cannot occur while empty (no fall-through).
- count is updated every cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- X on out1/out2 while en=0 is ignored.

Test Plan:
- Reset, en=1, out1=0, out2=0 for 5 cycles -> rd_valid stays 0, count=0, overflow=0.
- After reset, en=1 from cycle 0; out1 0->0x0005 sampled at cyc=3 -> one entry {3, 2'b10, 0x0005, 0x0000}, rd_valid high one cycle later, popped with rd_ready=1 -> count back to 0.
- out1->0x0011 and out2->0x0022 at the same edge, cyc=7 -> a single entry {7, 2'b11, 0x0011, 0x0022}.
- rd_ready=0; change out2 every cycle for 10 cycles (DEPTH=8) -> count=8, overflow=1, first 8 stamps retained in order. Then rd_ready=1 for 8 cycles -> stamps drained in order, rd_valid=0, overflow still 1.
- FIFO full; rd_ready=1 and a new change in the same cycle -> count stays 8, overflow remains 0.
- Entries pending, en toggled 0 for 4 cycles (out1 changing), then rst=1 for one cycle -> no entries logged while en=0; after rst: count=0, rd_valid=0, cyc restarts at 0.
